// File: rtl/seq_detect_sched.sv
// Serial 4-bit pattern detector: accepts 8-bit words, shifts them MSB first through a
// persistent history and reports the per-word match count plus a saturating total.
module seq_detect_sched (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_pattern,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [3:0]  m_hits,
  output logic [15:0] total_hits,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StShift  = 2'b01,
    StReport = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  pattern_q, pattern_d;
  logic [3:0]  hist_q, hist_d;
  logic [2:0]  hcnt_q, hcnt_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  m_hits_q, m_hits_d;
  logic [15:0] total_q, total_d;

  logic       bit_in;
  logic [3:0] hist_upd;
  logic [2:0] hcnt_upd;
  logic       match;

  // History update for the bit currently being shifted out of the captured word.
  always_comb begin
    bit_in   = data_q[idx_q];
    hist_upd = {hist_q[2:0], bit_in};
    hcnt_upd = (hcnt_q >= 3'd4) ? 3'd4 : hcnt_q + 3'd1;
    match    = (hist_upd == pattern_q) && (hcnt_upd == 3'd4);
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    hist_d    = hist_q;
    hcnt_d    = hcnt_q;
    data_d    = data_q;
    idx_d     = idx_q;
    m_hits_d  = m_hits_q;
    total_d   = total_q;

    if (clr) begin
      // Pattern survives clr; everything else, including an in-flight word, is dropped.
      state_d  = StIdle;
      hist_d   = 4'd0;
      hcnt_d   = 3'd0;
      m_hits_d = 4'd0;
      total_d  = 16'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cfg_we) begin
            pattern_d = cfg_pattern;
          end
          if (s_valid) begin
            data_d   = s_data;
            idx_d    = 3'd7;
            m_hits_d = 4'd0;
            state_d  = StShift;
          end
        end
        StShift: begin
          hist_d = hist_upd;
          hcnt_d = hcnt_upd;
          if (match) begin
            m_hits_d = m_hits_q + 4'd1;
            total_d  = (total_q == 16'hFFFF) ? total_q : total_q + 16'd1;
          end
          if (idx_q == 3'd0) begin
            state_d = StReport;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end
        StReport: begin
          if (m_ready) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      pattern_q <= 4'b0110;
      hist_q    <= 4'd0;
      hcnt_q    <= 3'd0;
      data_q    <= 8'd0;
      idx_q     <= 3'd0;
      m_hits_q  <= 4'd0;
      total_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      hcnt_q    <= hcnt_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      m_hits_q  <= m_hits_d;
      total_q   <= total_d;
    end
  end

  // Handshake/status outputs decode directly from the state register.
  assign s_ready    = (state_q == StIdle);
  assign m_valid    = (state_q == StReport);
  assign busy       = (state_q != StIdle);
  assign m_hits     = m_hits_q;
  assign total_hits = total_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Randomized bench for seq_detect_sched against a bit-queue reference model.
module tb_seq_detect_sched;

  logic        clk;
  logic        rstn;
  logic        clr;
  logic        cfg_we;
  logic [3:0]  cfg_pattern;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  m_hits;
  logic [15:0] total_hits;
  logic        busy;

  int n_checks;
  int n_pass;

  // Reference model: the last (up to) four bits seen since reset/clr.
  bit          hist_m[$];
  logic [3:0]  pat_m;
  int unsigned total_m;

  seq_detect_sched u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (clr),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_hits     (m_hits),
    .total_hits (total_hits),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int model_word(input logic [7:0] d);
    int hits;
    hits = 0;
    for (int i = 7; i >= 0; i--) begin
      hist_m.push_back(d[i]);
      if (hist_m.size() > 4) void'(hist_m.pop_front());
      if (hist_m.size() == 4 && {hist_m[0], hist_m[1], hist_m[2], hist_m[3]} == pat_m) hits++;
    end
    total_m = (total_m + hits > 65535) ? 65535 : total_m + hits;
    return hits;
  endfunction

  task automatic model_clear();
    hist_m.delete();
    total_m = 0;
  endtask

  task automatic send_word(input logic [7:0] d, input int delay, input bit cfg_now,
                           input logic [3:0] new_pat, input bit cfg_in_shift);
    int cyc;
    int exp_hits;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    if (cfg_now) begin
      cfg_we      = 1'b1;
      cfg_pattern = new_pat;
    end
    cyc = 0;
    while (!s_ready && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    if (!s_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    cfg_we  = 1'b0;
    if (cfg_now) pat_m = new_pat;
    exp_hits = model_word(d);
    check("busy_after_accept", busy, 1);
    check("sready_in_shift", s_ready, 0);
    cyc = 0;
    while (!m_valid && cyc < 30) begin
      if (cfg_in_shift && cyc == 3) begin
        cfg_we      = 1'b1;
        cfg_pattern = 4'b1111;
      end else begin
        cfg_we = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    cfg_we = 1'b0;
    check("latency", cyc, 8);
    check("m_hits", m_hits, exp_hits);
    check("total_hits", total_hits, total_m);
    check("sready_in_report", s_ready, 0);
    for (int k = 0; k < delay; k++) begin
      @(posedge clk);
      #1;
      check("hold_valid", m_valid, 1);
      check("hold_hits", m_hits, exp_hits);
      check("hold_sready", s_ready, 0);
    end
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check("idle_after_ack", busy, 0);
    check("valid_after_ack", m_valid, 0);
  endtask

  task automatic cfg_write(input logic [3:0] p);
    @(negedge clk);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    pat_m  = p;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_clear();
    check("clr_total", total_hits, 0);
  endtask

  // Accept a word, then abort it with clr (use_rst=0) or rstn (use_rst=1) after k edges.
  task automatic abort_word(input logic [7:0] d, input int k, input bit use_rst);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
    if (use_rst) begin
      rstn = 1'b0;
      #1;
      check("rst_sready", s_ready, 1);
      check("rst_mvalid", m_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_total", total_hits, 0);
      @(negedge clk);
      rstn = 1'b1;
      pat_m = 4'b0110;
      model_clear();
    end else begin
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      model_clear();
      check("clr_busy", busy, 0);
      check("clr_mvalid", m_valid, 0);
      check("clr_sready", s_ready, 1);
      check("clr_total", total_hits, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rstn        = 1'b0;
    clr         = 1'b0;
    cfg_we      = 1'b0;
    cfg_pattern = 4'd0;
    s_valid     = 1'b0;
    s_data      = 8'd0;
    m_ready     = 1'b0;
    pat_m       = 4'b0110;
    model_clear();
    #12;
    check("reset_sready", s_ready, 1);
    check("reset_mvalid", m_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_total", total_hits, 0);
    check("reset_hits", m_hits, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Default pattern 0110 on 0110_0110.
    send_word(8'h66, 0, 1'b0, 4'd0, 1'b0);

    // Overlapping matches: pattern 1010 over 1010_1010.
    cfg_write(4'b1010);
    do_clr();
    send_word(8'hAA, 1, 1'b0, 4'd0, 1'b0);

    // Cross-word match after a fresh reset.
    abort_word(8'h00, 0, 1'b1);
    send_word(8'h03, 0, 1'b0, 4'd0, 1'b0);
    send_word(8'h00, 5, 1'b0, 4'd0, 1'b0);

    // Config write during SHIFT is ignored; 0xFF would hit under 1111.
    send_word(8'hFF, 2, 1'b0, 4'd0, 1'b1);
    send_word(8'hFF, 0, 1'b0, 4'd0, 1'b0);

    // clr at bit index 3, then 0x60 under 0110.
    abort_word(8'hF0, 4, 1'b0);
    send_word(8'h60, 0, 1'b0, 4'd0, 1'b0);

    // Reset mid-SHIFT restores the default pattern.
    cfg_write(4'b1001);
    abort_word(8'h55, 3, 1'b1);
    send_word(8'h36, 0, 1'b0, 4'd0, 1'b0);

    // Config write coincident with handshake applies to that word.
    send_word(8'hA5, 1, 1'b1, 4'b0101, 1'b0);

    // clr with s_valid in IDLE must not accept the word.
    @(negedge clk);
    clr     = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    @(posedge clk);
    #1;
    clr     = 1'b0;
    s_valid = 1'b0;
    model_clear();
    check("clr_blocks_accept", busy, 0);

    for (int it = 0; it < 40; it++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        cfg_write(4'($urandom));
      end else if (r == 1) begin
        do_clr();
      end else if (r == 2) begin
        abort_word(8'($urandom), $urandom_range(1, 8), 1'b0);
      end else begin
        send_word(8'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                  4'($urandom), ($urandom_range(0, 3) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
